aud_session_ctrl: RTL and testbench
===================================

Name: aud_session_ctrl

Overview:
- Top-level session sequencer for the Lab3 audio recorder.
- Turns debounced user key pulses into the start/pause/stop command pulses for AudRecorder and AudDSP.
- Records the length of the last recording and hands it to AudDSP as the playback end address.
- Gates AudPlayer enable and the SRAM write strobe, so recorder and player never own SRAM together.

Parameters:
- ADDR_W, 20: width of SRAM word addresses.
- MAX_ADDR, 20'hFFFFF: last usable SRAM word address; recording auto-stops here.
- PULSE_CYC, 2: number of cycles each o_rec_*/o_dsp_* command pulse is held high. Legal range is 1..7.

Ports:
- i_clk, in, 1: system clock.
- i_rst_n, in, 1: asynchronous active-low reset.
- i_init_done, in, 1: I2C codec initialization complete (level).
- i_key_start, in, 1: start/resume request, one-cycle pulse.
- i_key_pause, in, 1: pause request, one-cycle pulse.
- i_key_stop, in, 1: stop request, one-cycle pulse.
- i_mode_rec, in, 1: 1 = record, 0 = play. Sampled only on a start accepted in S_IDLE.
- i_rec_addr, in, ADDR_W: current AudRecorder write address.
- i_dsp_done, in, 1: AudDSP reached o_end_addr (one-cycle pulse).
- o_rec_start, o_rec_pause, o_rec_stop, out, 1 each: AudRecorder commands.
- o_dsp_start, o_dsp_pause, o_dsp_stop, out, 1 each: AudDSP commands.
- o_end_addr, out, ADDR_W: last address written by the most recent recording.
- o_end_valid, out, 1: o_end_addr holds a completed recording.
- o_player_en, out, 1: AudPlayer i_en.
- o_sram_we_n, out, 1: SRAM write enable, active low.
- o_state, out, 3: current state, for the 7-segment display.

Behaviour:
- Reset values:
  - state = S_INIT.
  - All command outputs = 0.
  - o_end_addr = 0, o_end_valid = 0, o_player_en = 0.
  - o_sram_we_n = 1.
- Reset asserted mid-operation aborts everything immediately. No stop pulse is emitted.
- State encoding: S_INIT = 0, S_IDLE = 1, S_REC = 2, S_REC_PAUSE = 3, S_PLAY = 4, S_PLAY_PAUSE = 5.
- S_INIT:
  - All keys are ignored.
  - Moves to S_IDLE on the first cycle i_init_done = 1.
- Key priority when keys arrive in the same cycle: stop > pause > start. Only the highest-priority key is acted on; the others are dropped.
- Command pulses:
  - Every accepted transition fires its pulse registered, i.e. it rises the cycle after the key.
  - The pulse is held for exactly PULSE_CYC cycles.
  - Keys arriving while a pulse counter is running are dropped, with no queueing.
- Transitions:
  - S_IDLE + start, i_mode_rec = 1: go to S_REC, pulse o_rec_start, clear o_end_valid.
  - S_IDLE + start, i_mode_rec = 0, o_end_valid = 1: go to S_PLAY, pulse o_dsp_start.
  - S_IDLE + start, i_mode_rec = 0, o_end_valid = 0: ignored; stay in S_IDLE.
  - S_REC + pause: go to S_REC_PAUSE, pulse o_rec_pause.
  - S_REC_PAUSE + start: go to S_REC, pulse o_rec_start.
  - S_REC or S_REC_PAUSE + stop: go to S_IDLE, pulse o_rec_stop, capture o_end_addr = i_rec_addr, set o_end_valid = 1.
  - S_REC with i_rec_addr == MAX_ADDR: same as stop (auto-stop), o_end_addr = MAX_ADDR.
  - S_PLAY + pause: go to S_PLAY_PAUSE, pulse o_dsp_pause.
  - S_PLAY_PAUSE + start: go to S_PLAY, pulse o_dsp_start.
  - S_PLAY or S_PLAY_PAUSE + stop: go to S_IDLE, pulse o_dsp_stop.
  - S_PLAY + i_dsp_done: go to S_IDLE, pulse o_dsp_stop.
- Keys with no listed transition are ignored in that state.
- Combinational outputs:
  - o_sram_we_n = 0 only in S_REC.
  - o_player_en = 1 only in S_PLAY.
  - o_state reflects the registered state.
- i_dsp_done is ignored outside S_PLAY.
- Simultaneous i_dsp_done and stop in S_PLAY give a single o_dsp_stop pulse.

Optional Feature:
- Macro: AUD_LOOP_PLAY_EN.
- Defined: i_dsp_done in S_PLAY keeps the block in S_PLAY and emits o_dsp_stop for PULSE_CYC cycles. After one idle cycle it emits o_dsp_start for PULSE_CYC cycles, so playback restarts from address 0. Keys are dropped during this sequence; o_player_en stays 1.
- Undefined: i_dsp_done behaves as a stop, as described in Behaviour.

Test Plan:
- Init gating: hold i_init_done = 0 for 10 cycles while pulsing i_key_start. Required: o_state = 0 and no command pulses. Raise i_init_done; required: o_state = 1 on the next cycle.
- Record session: start with i_mode_rec = 1, then pause, then start, then stop while i_rec_addr = 20'h00123. Required:
  - o_rec_start, o_rec_pause, o_rec_start, o_rec_stop each held 2 cycles.
  - o_sram_we_n = 0 only in S_REC.
  - o_end_addr = 20'h00123, o_end_valid = 1.
- Play without recording: after reset, start with i_mode_rec = 0. Required: o_state stays 1 and o_dsp_start stays 0.
- Playback end: record, then start with i_mode_rec = 0, then pulse i_dsp_done. Required:
  - o_player_en = 1 while in S_PLAY.
  - o_dsp_stop pulse, then o_state = 1 and o_player_en = 0.
  - With AUD_LOOP_PLAY_EN: o_dsp_stop, one idle cycle, o_dsp_start, o_state stays 4.
- Priority and auto-stop:
  - Pulse start, pause and stop together in S_REC. Required: only o_rec_stop fires.
  - Drive i_rec_addr = 20'hFFFFF in S_REC. Required: o_rec_stop fires and o_end_addr = 20'hFFFFF.
- Async reset mid-play: drop i_rst_n in S_PLAY between clock edges. Required: all outputs return to reset values immediately and o_end_valid = 0.

Source files
------------

// File: rtl/aud_session_ctrl.sv
// Lab3 audio recorder session sequencer: key pulses -> registered recorder/DSP command pulses,
// SRAM ownership gating and last-recording length. Define AUD_LOOP_PLAY_EN for looped playback.
module aud_session_ctrl #(
  parameter int                ADDR_W    = 20,
  parameter logic [ADDR_W-1:0] MAX_ADDR  = 20'hFFFFF,
  parameter int                PULSE_CYC = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_init_done,
  input  logic              i_key_start,
  input  logic              i_key_pause,
  input  logic              i_key_stop,
  input  logic              i_mode_rec,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic              i_dsp_done,
  output logic              o_rec_start,
  output logic              o_rec_pause,
  output logic              o_rec_stop,
  output logic              o_dsp_start,
  output logic              o_dsp_pause,
  output logic              o_dsp_stop,
  output logic [ADDR_W-1:0] o_end_addr,
  output logic              o_end_valid,
  output logic              o_player_en,
  output logic              o_sram_we_n,
  output logic [2:0]        o_state
);

  typedef enum logic [2:0] {
    S_INIT       = 3'd0,
    S_IDLE       = 3'd1,
    S_REC        = 3'd2,
    S_REC_PAUSE  = 3'd3,
    S_PLAY       = 3'd4,
    S_PLAY_PAUSE = 3'd5
  } state_t;

  localparam logic [5:0] CMD_REC_START = 6'b000001;
  localparam logic [5:0] CMD_REC_PAUSE = 6'b000010;
  localparam logic [5:0] CMD_REC_STOP  = 6'b000100;
  localparam logic [5:0] CMD_DSP_START = 6'b001000;
  localparam logic [5:0] CMD_DSP_PAUSE = 6'b010000;
  localparam logic [5:0] CMD_DSP_STOP  = 6'b100000;
  localparam logic [2:0] CNT_INIT      = 3'(PULSE_CYC - 1);

  state_t              state_q, state_d;
  logic [5:0]          cmd_q, cmd_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   end_addr_q, end_addr_d;
  logic                end_valid_q, end_valid_d;
  logic [5:0]          fire_cmd;
  logic                loop_busy;
  logic                busy;
  logic                k_start, k_pause, k_stop;
  logic                rec_full;

`ifdef AUD_LOOP_PLAY_EN
  localparam logic [1:0] LOOP_NONE = 2'd0;
  localparam logic [1:0] LOOP_STOP = 2'd1;
  localparam logic [1:0] LOOP_GAP  = 2'd2;
  logic [1:0] loop_q, loop_d;
  assign loop_busy = (loop_q != LOOP_NONE);
`else
  assign loop_busy = 1'b0;
`endif

  // Keys are dropped while any command pulse (or loop restart) is in flight.
  assign busy     = (cmd_q != 6'd0) | loop_busy;
  assign k_stop   = i_key_stop & ~busy;
  assign k_pause  = i_key_pause & ~i_key_stop & ~busy;
  assign k_start  = i_key_start & ~i_key_pause & ~i_key_stop & ~busy;
  assign rec_full = (i_rec_addr == MAX_ADDR);

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    end_addr_d  = end_addr_q;
    end_valid_d = end_valid_q;
    fire_cmd    = 6'd0;
`ifdef AUD_LOOP_PLAY_EN
    loop_d      = loop_q;
`endif

    if (cmd_q != 6'd0) begin
      if (cnt_q == 3'd0) begin
        cmd_d = 6'd0;
`ifdef AUD_LOOP_PLAY_EN
        if (loop_q == LOOP_STOP) loop_d = LOOP_GAP;
`endif
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
    end

    case (state_q)
      S_INIT: begin
        if (i_init_done) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (k_start) begin
          if (i_mode_rec) begin
            state_d     = S_REC;
            fire_cmd    = CMD_REC_START;
            end_valid_d = 1'b0;
          end else if (end_valid_q) begin
            state_d  = S_PLAY;
            fire_cmd = CMD_DSP_START;
          end
        end
      end
      S_REC: begin
        // Hitting the last SRAM word ends the take exactly like a stop key.
        if (k_stop || rec_full) begin
          state_d     = S_IDLE;
          fire_cmd    = CMD_REC_STOP;
          end_addr_d  = i_rec_addr;
          end_valid_d = 1'b1;
        end else if (k_pause) begin
          state_d  = S_REC_PAUSE;
          fire_cmd = CMD_REC_PAUSE;
        end
      end
      S_REC_PAUSE: begin
        if (k_stop) begin
          state_d     = S_IDLE;
          fire_cmd    = CMD_REC_STOP;
          end_addr_d  = i_rec_addr;
          end_valid_d = 1'b1;
        end else if (k_start) begin
          state_d  = S_REC;
          fire_cmd = CMD_REC_START;
        end
      end
      S_PLAY: begin
`ifdef AUD_LOOP_PLAY_EN
        if (loop_q == LOOP_GAP) begin
          fire_cmd = CMD_DSP_START;
          loop_d   = LOOP_NONE;
        end else if (k_stop) begin
          state_d  = S_IDLE;
          fire_cmd = CMD_DSP_STOP;
        end else if (i_dsp_done && (loop_q == LOOP_NONE)) begin
          fire_cmd = CMD_DSP_STOP;
          loop_d   = LOOP_STOP;
        end else if (k_pause) begin
          state_d  = S_PLAY_PAUSE;
          fire_cmd = CMD_DSP_PAUSE;
        end
`else
        if (k_stop || i_dsp_done) begin
          state_d  = S_IDLE;
          fire_cmd = CMD_DSP_STOP;
        end else if (k_pause) begin
          state_d  = S_PLAY_PAUSE;
          fire_cmd = CMD_DSP_PAUSE;
        end
`endif
      end
      S_PLAY_PAUSE: begin
        if (k_stop) begin
          state_d  = S_IDLE;
          fire_cmd = CMD_DSP_STOP;
        end else if (k_start) begin
          state_d  = S_PLAY;
          fire_cmd = CMD_DSP_START;
        end
      end
      default: state_d = S_INIT;
    endcase

    if (fire_cmd != 6'd0) begin
      cmd_d = fire_cmd;
      cnt_d = CNT_INIT;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_INIT;
      cmd_q       <= 6'd0;
      cnt_q       <= 3'd0;
      end_addr_q  <= '0;
      end_valid_q <= 1'b0;
`ifdef AUD_LOOP_PLAY_EN
      loop_q      <= LOOP_NONE;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      end_addr_q  <= end_addr_d;
      end_valid_q <= end_valid_d;
`ifdef AUD_LOOP_PLAY_EN
      loop_q      <= loop_d;
`endif
    end
  end

  assign o_rec_start = cmd_q[0];
  assign o_rec_pause = cmd_q[1];
  assign o_rec_stop  = cmd_q[2];
  assign o_dsp_start = cmd_q[3];
  assign o_dsp_pause = cmd_q[4];
  assign o_dsp_stop  = cmd_q[5];
  assign o_end_addr  = end_addr_q;
  assign o_end_valid = end_valid_q;
  assign o_player_en = (state_q == S_PLAY);
  assign o_sram_we_n = (state_q != S_REC);
  assign o_state     = state_q;

endmodule

// File: tb/tb_aud_session_ctrl.sv
// Bench for aud_session_ctrl: directed test-plan steps then random keys, checked against a
// schedule-queue reference model (expected command per future cycle).
module tb_aud_session_ctrl;

  localparam int         P    = 2;
  localparam logic [19:0] MAXA = 20'hFFFFF;
  localparam logic [2:0] S_INIT = 3'd0, S_IDLE = 3'd1, S_REC = 3'd2, S_REC_PAUSE = 3'd3,
                         S_PLAY = 3'd4, S_PLAY_PAUSE = 3'd5;
  localparam logic [5:0] C_RS = 6'b000001, C_RP = 6'b000010, C_RT = 6'b000100,
                         C_DS = 6'b001000, C_DP = 6'b010000, C_DT = 6'b100000;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_init_done, i_key_start, i_key_pause, i_key_stop, i_mode_rec, i_dsp_done;
  logic [19:0] i_rec_addr;
  logic        o_rec_start, o_rec_pause, o_rec_stop, o_dsp_start, o_dsp_pause, o_dsp_stop;
  logic [19:0] o_end_addr;
  logic        o_end_valid, o_player_en, o_sram_we_n;
  logic [2:0]  o_state;

  aud_session_ctrl #(.ADDR_W(20), .MAX_ADDR(MAXA), .PULSE_CYC(P)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_init_done(i_init_done),
    .i_key_start(i_key_start), .i_key_pause(i_key_pause), .i_key_stop(i_key_stop),
    .i_mode_rec(i_mode_rec), .i_rec_addr(i_rec_addr), .i_dsp_done(i_dsp_done),
    .o_rec_start(o_rec_start), .o_rec_pause(o_rec_pause), .o_rec_stop(o_rec_stop),
    .o_dsp_start(o_dsp_start), .o_dsp_pause(o_dsp_pause), .o_dsp_stop(o_dsp_stop),
    .o_end_addr(o_end_addr), .o_end_valid(o_end_valid), .o_player_en(o_player_en),
    .o_sram_we_n(o_sram_we_n), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: state, captured length, and a queue of commands for upcoming cycles.
  logic [2:0]  m_state;
  logic [5:0]  m_cmd;
  logic [5:0]  sched[$];
  logic [19:0] m_end;
  logic        m_valid;

  wire [5:0] dut_cmd = {o_dsp_stop, o_dsp_pause, o_dsp_start, o_rec_stop, o_rec_pause, o_rec_start};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/state_cmd"}, {23'd0, o_state, dut_cmd}, {23'd0, m_state, m_cmd});
    chk({tag, "/we_player"}, {30'd0, o_sram_we_n, o_player_en},
        {30'd0, (m_state != S_REC), (m_state == S_PLAY)});
    chk({tag, "/end"}, {11'd0, o_end_valid, o_end_addr}, {11'd0, m_valid, m_end});
  endtask

  task automatic model_reset();
    m_state = S_INIT;
    m_cmd   = 6'd0;
    sched.delete();
    m_end   = 20'd0;
    m_valid = 1'b0;
  endtask

  task automatic model_edge();
    logic       busy;
    int         key;
    logic [5:0] fire;
    logic [2:0] nxt;
    busy = (m_cmd != 6'd0) || (sched.size() != 0);
    key  = 0;
    if (!busy) begin
      if (i_key_stop) key = 3;
      else if (i_key_pause) key = 2;
      else if (i_key_start) key = 1;
    end
    fire = 6'd0;
    nxt  = m_state;
    case (m_state)
      S_INIT: if (i_init_done) nxt = S_IDLE;
      S_IDLE: if (key == 1) begin
        if (i_mode_rec) begin nxt = S_REC; fire = C_RS; m_valid = 1'b0; end
        else if (m_valid) begin nxt = S_PLAY; fire = C_DS; end
      end
      S_REC: begin
        if (key == 3 || i_rec_addr == MAXA) begin
          nxt = S_IDLE; fire = C_RT; m_end = i_rec_addr; m_valid = 1'b1;
        end else if (key == 2) begin nxt = S_REC_PAUSE; fire = C_RP; end
      end
      S_REC_PAUSE: begin
        if (key == 3) begin nxt = S_IDLE; fire = C_RT; m_end = i_rec_addr; m_valid = 1'b1; end
        else if (key == 1) begin nxt = S_REC; fire = C_RS; end
      end
      S_PLAY: begin
        if (key == 3) begin nxt = S_IDLE; fire = C_DT; end
        else if (i_dsp_done) begin
`ifdef AUD_LOOP_PLAY_EN
          sched.delete();
          repeat (P) sched.push_back(C_DT);
          sched.push_back(6'd0);
          repeat (P) sched.push_back(C_DS);
`else
          nxt = S_IDLE; fire = C_DT;
`endif
        end else if (key == 2) begin nxt = S_PLAY_PAUSE; fire = C_DP; end
      end
      S_PLAY_PAUSE: begin
        if (key == 3) begin nxt = S_IDLE; fire = C_DT; end
        else if (key == 1) begin nxt = S_PLAY; fire = C_DS; end
      end
      default: nxt = S_INIT;
    endcase
    if (fire != 6'd0) begin
      sched.delete();
      repeat (P) sched.push_back(fire);
    end
    m_cmd   = (sched.size() != 0) ? sched.pop_front() : 6'd0;
    m_state = nxt;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge i_clk);
    #1;
    i_key_start = 1'b0;
    i_key_pause = 1'b0;
    i_key_stop  = 1'b0;
    i_dsp_done  = 1'b0;
    check_all(tag);
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) step(tag);
  endtask

  initial begin
    i_rst_n = 1'b0; i_init_done = 1'b0; i_key_start = 1'b0; i_key_pause = 1'b0;
    i_key_stop = 1'b0; i_mode_rec = 1'b0; i_dsp_done = 1'b0; i_rec_addr = 20'd0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check_all("reset");
    i_rst_n = 1'b1;

    // Init gating: keys ignored until codec init completes.
    for (int i = 0; i < 10; i++) begin
      i_key_start = (i % 2 == 0);
      step("init_gate");
    end
    chk("init_hold_state", {29'd0, o_state}, {29'd0, S_INIT});
    i_init_done = 1'b1;
    step("init_done");
    chk("init_to_idle", {29'd0, o_state}, {29'd0, S_IDLE});

    // Play with nothing recorded is ignored.
    i_mode_rec = 1'b0; i_key_start = 1'b1;
    step("play_norec");
    run(3, "play_norec");
    chk("play_norec_state", {29'd0, o_state}, {29'd0, S_IDLE});

    // Record session: start, pause, resume, stop at 0x00123.
    i_mode_rec = 1'b1; i_rec_addr = 20'h00010; i_key_start = 1'b1;
    step("rec_start");
    chk("rec_start_c1", {31'd0, o_rec_start}, 32'd1);
    chk("rec_we_low", {31'd0, o_sram_we_n}, 32'd0);
    step("rec_start");
    chk("rec_start_c2", {31'd0, o_rec_start}, 32'd1);
    step("rec_start");
    chk("rec_start_end", {31'd0, o_rec_start}, 32'd0);
    i_key_pause = 1'b1;
    step("rec_pause");
    chk("rec_pause_we_high", {31'd0, o_sram_we_n}, 32'd1);
    run(3, "rec_pause");
    i_key_start = 1'b1;
    step("rec_resume");
    run(3, "rec_resume");
    i_rec_addr = 20'h00123; i_key_stop = 1'b1;
    step("rec_stop");
    run(3, "rec_stop");
    chk("rec_end_addr", {12'd0, o_end_addr}, 32'h00123);
    chk("rec_end_valid", {31'd0, o_end_valid}, 32'd1);

    // Playback end via i_dsp_done.
    i_mode_rec = 1'b0; i_key_start = 1'b1;
    step("play_start");
    run(3, "play_run");
    chk("play_player_en", {31'd0, o_player_en}, 32'd1);
    i_dsp_done = 1'b1;
    step("play_done");
    chk("play_done_stop", {31'd0, o_dsp_stop}, 32'd1);
    run(P + 3, "play_after_done");
`ifdef AUD_LOOP_PLAY_EN
    chk("loop_state", {29'd0, o_state}, {29'd0, S_PLAY});
`else
    chk("done_state", {29'd0, o_state}, {29'd0, S_IDLE});
    chk("done_player_off", {31'd0, o_player_en}, 32'd0);
`endif
    i_key_stop = 1'b1;
    step("play_exit");
    run(3, "play_exit");

    // Priority: all keys together in S_REC -> stop only.
    i_mode_rec = 1'b1; i_rec_addr = 20'h00040; i_key_start = 1'b1;
    step("prio_rec");
    run(3, "prio_rec");
    i_key_start = 1'b1; i_key_pause = 1'b1; i_key_stop = 1'b1;
    step("prio_keys");
    chk("prio_only_stop", {26'd0, dut_cmd}, {26'd0, C_RT});
    run(3, "prio_after");

    // Auto-stop at the last SRAM word.
    i_key_start = 1'b1;
    step("auto_rec");
    run(3, "auto_rec");
    i_rec_addr = MAXA;
    step("auto_stop");
    chk("auto_stop_pulse", {31'd0, o_rec_stop}, 32'd1);
    i_rec_addr = 20'd0;
    run(3, "auto_after");
    chk("auto_end_addr", {12'd0, o_end_addr}, {12'd0, MAXA});

    // Random key traffic.
    for (int i = 0; i < 1500; i++) begin
      i_key_start = ($urandom_range(0, 99) < 8);
      i_key_pause = ($urandom_range(0, 99) < 5);
      i_key_stop  = ($urandom_range(0, 99) < 4);
      i_mode_rec  = $urandom_range(0, 1) != 0;
      i_rec_addr  = ($urandom_range(0, 199) == 0) ? MAXA : 20'($urandom_range(0, 4095));
      i_dsp_done  = (m_state == S_PLAY) && (m_cmd == 6'd0) && (sched.size() == 0)
                    && ($urandom_range(0, 29) == 0);
      step("rand");
    end

    // Async reset mid-play: reach S_PLAY, then drop reset between edges.
    i_rec_addr = 20'd0; i_dsp_done = 1'b0;
    run(8, "rst_settle");
    i_key_stop = 1'b1;
    step("rst_stop");
    run(8, "rst_settle");
    i_mode_rec = 1'b1; i_key_start = 1'b1;
    step("rst_rec");
    run(3, "rst_rec");
    i_rec_addr = 20'h00777; i_key_stop = 1'b1;
    step("rst_recstop");
    run(3, "rst_recstop");
    i_mode_rec = 1'b0; i_key_start = 1'b1;
    step("rst_play");
    step("rst_play");
    chk("rst_in_play", {29'd0, o_state}, {29'd0, S_PLAY});
    #2;
    i_rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst_valid", {31'd0, o_end_valid}, 32'd0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    run(4, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
